vdp_cpu_port: RTL and testbench

//  Parametrised CPU-side port of the VDP. Decodes the two-port (data/control) TMS9918-style protocol

---
 rtl/vdp_cpu_port.sv | 161 ++++++++++++++++
 tb/tb_vdp_cpu_port.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/vdp_cpu_port.sv
// CPU-side port of the VDP: TMS9918-style data/control decode, register file,
// auto-incrementing VRAM pointer, ordered VRAM request FIFO, read-ahead buffer and status.
module vdp_cpu_port #(
  parameter int ADDR_W     = 14,
  parameter int NUM_REGS   = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_wr,
  input  logic                  cpu_rd,
  input  logic                  cpu_a0,
  input  logic [7:0]            cpu_din,
  output logic [7:0]            cpu_dout,
  output logic                  cpu_wait,
  output logic                  vram_req,
  output logic                  vram_we,
  output logic [ADDR_W-1:0]     vram_addr,
  output logic [7:0]            vram_wdata,
  input  logic                  vram_ack,
  input  logic [7:0]            vram_rdata,
  input  logic                  vblank,
  output logic                  irq,
  output logic [NUM_REGS*8-1:0] regs
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [7:0]        reg_file [NUM_REGS];
  logic [ADDR_W-1:0] pointer;
  logic [ADDR_W-1:0] ptr_next;
  logic [ADDR_W-1:0] set_addr;
  logic [7:0]        latch_byte;
  logic              flag;
  logic [7:0]        read_buf;
  logic              status_f;
  logic              status_ovf;

  logic              fifo_we   [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [7:0]        fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_idx;
  logic [PTR_W-1:0]  rd_idx;
  logic [CNT_W-1:0]  count;

  logic data_wr, ctrl_wr, data_rd, ctrl_rd, rd_valid;
  logic enq_req, enq_we, enq_ok, pop, fifo_full, ovf_set;
  logic [ADDR_W-1:0] enq_addr;
  logic [7:0]        enq_data;

  // A write strobe wins over a coincident read strobe; the read is simply ignored.
  assign rd_valid = cpu_rd & ~cpu_wr;
  assign data_wr  = cpu_wr & ~cpu_a0;
  assign ctrl_wr  = cpu_wr & cpu_a0;
  assign data_rd  = rd_valid & ~cpu_a0;
  assign ctrl_rd  = rd_valid & cpu_a0;

  assign set_addr = ADDR_W'({cpu_din[5:0], latch_byte});

  always_comb begin
    enq_req  = 1'b0;
    enq_we   = 1'b0;
    enq_addr = pointer;
    enq_data = 8'h00;
    ptr_next = pointer;
    if (data_wr) begin
      enq_req  = 1'b1;
      enq_we   = 1'b1;
      enq_data = cpu_din;
      ptr_next = pointer + ADDR_W'(1);
    end else if (ctrl_wr && flag && !cpu_din[7]) begin
      ptr_next = set_addr;
      if (!cpu_din[6]) begin
        enq_req  = 1'b1;
        enq_addr = set_addr;
        ptr_next = set_addr + ADDR_W'(1);
      end
    end else if (data_rd) begin
      enq_req  = 1'b1;
      ptr_next = pointer + ADDR_W'(1);
    end
  end

  // A pop in the same cycle frees a slot, so a full FIFO can still accept that enqueue.
  assign fifo_full = (count == CNT_W'(FIFO_DEPTH));
  assign pop       = vram_req & vram_ack;
  assign enq_ok    = enq_req & (~fifo_full | pop);
  assign ovf_set   = enq_req & fifo_full & ~pop;

  assign vram_req   = (count != '0);
  assign vram_we    = vram_req & fifo_we[rd_idx];
  assign vram_addr  = vram_req ? fifo_addr[rd_idx] : '0;
  assign vram_wdata = vram_req ? fifo_data[rd_idx] : 8'h00;
  assign cpu_wait   = fifo_full;

  always_ff @(posedge clk) begin
    if (enq_ok) begin
      fifo_we[wr_idx]   <= enq_we;
      fifo_addr[wr_idx] <= enq_addr;
      fifo_data[wr_idx] <= enq_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_idx   <= '0;
      rd_idx   <= '0;
      count    <= '0;
      read_buf <= 8'h00;
    end else begin
      if (enq_ok) wr_idx <= wr_idx + PTR_W'(1);
      if (pop) rd_idx <= rd_idx + PTR_W'(1);
      count <= count + CNT_W'(enq_ok) - CNT_W'(pop);
      if (pop && !fifo_we[rd_idx]) read_buf <= vram_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pointer    <= '0;
      latch_byte <= 8'h00;
      flag       <= 1'b0;
      cpu_dout   <= 8'h00;
      status_f   <= 1'b0;
      status_ovf <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) reg_file[i] <= 8'h00;
    end else begin
      pointer <= ptr_next;
      if (ctrl_wr) begin
        if (!flag) begin
          latch_byte <= cpu_din;
          flag       <= 1'b1;
        end else begin
          flag <= 1'b0;
          if (cpu_din[7]) begin
            for (int i = 0; i < NUM_REGS; i++)
              if (cpu_din[3:0] == 4'(i)) reg_file[i] <= latch_byte;
          end
        end
      end
      if (data_wr || data_rd || ctrl_rd) flag <= 1'b0;
      if (data_rd) cpu_dout <= read_buf;
      if (ctrl_rd) cpu_dout <= {status_f, fifo_full, status_ovf, 5'b0};
      // A vblank arriving with the status read survives the clear.
      status_f   <= vblank | (status_f & ~ctrl_rd);
      status_ovf <= ovf_set | (status_ovf & ~ctrl_rd);
    end
  end

  for (genvar n = 0; n < NUM_REGS; n++) begin : g_regs
    assign regs[8*n +: 8] = reg_file[n];
  end

  if (NUM_REGS >= 2) begin : g_irq
    assign irq = status_f & reg_file[1][5];
  end else begin : g_no_irq
    assign irq = 1'b0;
  end

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Directed bench for vdp_cpu_port: register writes, VRAM ordering, prefetch, overflow,
// frame interrupt, pointer wrap and asynchronous reset.
module tb_vdp_cpu_port;

  localparam int ADDR_W     = 14;
  localparam int NUM_REGS   = 8;
  localparam int FIFO_DEPTH = 4;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  cpu_wr = 1'b0;
  logic                  cpu_rd = 1'b0;
  logic                  cpu_a0 = 1'b0;
  logic [7:0]            cpu_din = 8'h00;
  logic [7:0]            cpu_dout;
  logic                  cpu_wait;
  logic                  vram_req;
  logic                  vram_we;
  logic [ADDR_W-1:0]     vram_addr;
  logic [7:0]            vram_wdata;
  logic                  vram_ack = 1'b0;
  logic [7:0]            vram_rdata = 8'h00;
  logic                  vblank = 1'b0;
  logic                  irq;
  logic [NUM_REGS*8-1:0] regs;

  int checks   = 0;
  int failures = 0;

  vdp_cpu_port #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_a0(cpu_a0),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_wait(cpu_wait), .vram_req(vram_req),
    .vram_we(vram_we), .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_ack(vram_ack),
    .vram_rdata(vram_rdata), .vblank(vblank), .irq(irq), .regs(regs)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // All tasks start and end on a falling edge, so the DUT is sampled mid-cycle.
  task automatic cpu_write(input logic a0, input logic [7:0] d);
    cpu_wr = 1'b1; cpu_a0 = a0; cpu_din = d;
    @(negedge clk);
    cpu_wr = 1'b0;
  endtask

  task automatic cpu_read(input logic a0);
    cpu_rd = 1'b1; cpu_a0 = a0;
    @(negedge clk);
    cpu_rd = 1'b0;
  endtask

  task automatic vram_expect(input string tag, input logic we, input logic [ADDR_W-1:0] addr,
                             input logic [7:0] data, input logic [7:0] rdata);
    int waited = 0;
    while (!vram_req && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!vram_req) begin
      check_output({tag, "_timeout"}, 64'(vram_req), 64'd1);
    end else begin
      check_output(tag, 64'({vram_we, vram_addr, (we ? vram_wdata : 8'h00)}),
                        64'({we, addr, (we ? data : 8'h00)}));
      vram_ack = 1'b1; vram_rdata = rdata;
      @(negedge clk);
      vram_ack = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    check_output("reset_regs", 64'(regs), 64'h0);
    check_output("reset_outs", 64'({cpu_dout, cpu_wait, vram_req, irq}), 64'h0);
    reset = 1'b0;
    @(negedge clk);

    cpu_write(1'b1, 8'h07); cpu_write(1'b1, 8'h87);
    check_output("reg7_write", 64'(regs), 64'h0700_0000_0000_0000);
    cpu_write(1'b1, 8'h11); cpu_write(1'b1, 8'h8F);
    check_output("reg15_discard", 64'(regs), 64'h0700_0000_0000_0000);
    cpu_write(1'b1, 8'h05); cpu_write(1'b1, 8'h81);
    check_output("flag_cleared", 64'(regs), 64'h0700_0000_0000_0500);
    check_output("no_req_after_regs", 64'(vram_req), 64'd0);

    cpu_write(1'b1, 8'h00); cpu_write(1'b1, 8'h40);
    check_output("set_ptr_no_access", 64'(vram_req), 64'd0);
    cpu_write(1'b0, 8'hAA); cpu_write(1'b0, 8'h55);
    vram_expect("wr_0000", 1'b1, 14'h0000, 8'hAA, 8'h00);
    vram_expect("wr_0001", 1'b1, 14'h0001, 8'h55, 8'h00);
    cpu_write(1'b0, 8'h77);
    vram_expect("wr_0002", 1'b1, 14'h0002, 8'h77, 8'h00);
    check_output("fifo_drained", 64'(vram_req), 64'd0);

    cpu_write(1'b1, 8'h00); cpu_write(1'b1, 8'h00);
    vram_expect("prefetch_0000", 1'b0, 14'h0000, 8'h00, 8'h3C);
    cpu_read(1'b0);
    check_output("data_read_3c", 64'(cpu_dout), 64'h3C);
    vram_expect("prefetch_0001", 1'b0, 14'h0001, 8'h00, 8'h99);
    cpu_read(1'b0);
    check_output("data_read_99", 64'(cpu_dout), 64'h99);
    vram_expect("prefetch_0002", 1'b0, 14'h0002, 8'h00, 8'h11);

    cpu_write(1'b1, 8'h00); cpu_write(1'b1, 8'h40);
    for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
      cpu_write(1'b0, 8'(8'h10 + i));
      if (i == FIFO_DEPTH - 2) check_output("wait_before_full", 64'(cpu_wait), 64'd0);
      if (i == FIFO_DEPTH - 1) check_output("wait_when_full", 64'(cpu_wait), 64'd1);
    end
    cpu_read(1'b1);
    check_output("status_full_ovf", 64'(cpu_dout), 64'h60);
    for (int i = 0; i < FIFO_DEPTH; i++)
      vram_expect("ovf_drain", 1'b1, 14'(i), 8'(8'h10 + i), 8'h00);
    check_output("fifth_dropped", 64'(vram_req), 64'd0);
    cpu_write(1'b0, 8'h20);
    vram_expect("ptr_after_drop", 1'b1, 14'h0005, 8'h20, 8'h00);
    cpu_read(1'b1);
    check_output("ovf_cleared", 64'(cpu_dout), 64'h00);

    cpu_write(1'b1, 8'h00); cpu_write(1'b1, 8'h40);
    for (int i = 0; i < FIFO_DEPTH; i++) cpu_write(1'b0, 8'(8'hA0 + i));
    check_output("refill_full", 64'(cpu_wait), 64'd1);
    cpu_wr = 1'b1; cpu_a0 = 1'b0; cpu_din = 8'hA4; vram_ack = 1'b1;
    @(negedge clk);
    cpu_wr = 1'b0; vram_ack = 1'b0;
    cpu_read(1'b1);
    check_output("enq_pop_no_ovf", 64'(cpu_dout), 64'h40);
    for (int i = 1; i <= FIFO_DEPTH; i++)
      vram_expect("enq_pop_drain", 1'b1, 14'(i), 8'(8'hA0 + i), 8'h00);
    check_output("enq_pop_empty", 64'(vram_req), 64'd0);

    cpu_write(1'b1, 8'h20); cpu_write(1'b1, 8'h81);
    check_output("irq_idle", 64'(irq), 64'd0);
    vblank = 1'b1; @(negedge clk); vblank = 1'b0;
    check_output("irq_on_vblank", 64'(irq), 64'd1);
    cpu_read(1'b1);
    check_output("status_frame", 64'(cpu_dout), 64'h80);
    check_output("irq_cleared", 64'(irq), 64'd0);
    cpu_rd = 1'b1; cpu_a0 = 1'b1; vblank = 1'b1;
    @(negedge clk);
    cpu_rd = 1'b0; vblank = 1'b0;
    check_output("coincident_old_f", 64'(cpu_dout), 64'h00);
    check_output("coincident_irq", 64'(irq), 64'd1);
    cpu_read(1'b1);

    cpu_write(1'b1, 8'hFF); cpu_write(1'b1, 8'h7F);
    cpu_write(1'b0, 8'h5A); cpu_write(1'b0, 8'h5B);
    vram_expect("wrap_3fff", 1'b1, 14'h3FFF, 8'h5A, 8'h00);
    vram_expect("wrap_0000", 1'b1, 14'h0000, 8'h5B, 8'h00);
    cpu_read(1'b1);
    check_output("wrap_no_status", 64'(cpu_dout), 64'h00);

    cpu_write(1'b1, 8'h10); cpu_write(1'b1, 8'h40);
    cpu_wr = 1'b1; cpu_rd = 1'b1; cpu_a0 = 1'b0; cpu_din = 8'h33;
    @(negedge clk);
    cpu_wr = 1'b0; cpu_rd = 1'b0;
    check_output("wr_rd_dout_held", 64'(cpu_dout), 64'h00);
    vram_expect("wr_rd_write", 1'b1, 14'h0010, 8'h33, 8'h00);
    check_output("wr_rd_no_prefetch", 64'(vram_req), 64'd0);

    cpu_write(1'b0, 8'h66);
    check_output("req_before_reset", 64'(vram_req), 64'd1);
    #2 reset = 1'b1;
    #1 check_output("req_async_drop", 64'(vram_req), 64'd0);
    check_output("regs_async_clear", 64'(regs), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_output("no_req_after_reset", 64'(vram_req), 64'd0);
    cpu_write(1'b0, 8'h81);
    vram_expect("ptr_reset", 1'b1, 14'h0000, 8'h81, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
